instr_packer: RTL and testbench



---
 rtl/instr_packer.sv | 172 +++++++++++++++++
 tb/tb_instr_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_packer.sv
// instr_packer
//   Packs the 32-bit instruction stream coming out of the looping instruction
//   buffer into 128-bit words (four slots, slot0 in the low bits) and hands
//   them to the instruction FIFO. An END_ISEQ opcode closes the sequence: the
//   partial word is padded with NOPs and flushed, then process_tr pulses once
//   so the dispatcher starts. The block then waits for the dispatcher to go
//   busy and back idle before accepting a new sequence.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   app_en/app_instr  instruction valid / data from the instruction buffer
//   app_ack           instruction taken this cycle when app_en & app_ack
//   fifo_full         instruction FIFO cannot take a word
//   fifo_wr_en        FIFO write strobe, fifo_din = packed word
//   dispatcher_busy   dispatcher is executing a sequence
//   process_tr        one-cycle pulse: whole sequence is in the FIFO
//   idle              block is waiting for the next sequence
//   instr_cnt         instructions accepted in this sequence (saturating)

// One assembly slot: keep what is already there, drop the incoming
// instruction into the current free slot, and pad everything above with NOPs.
module instr_packer_slot #(
  parameter int          IDX       = 0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic [1:0]  slot_i,
  input  logic [31:0] asm_i,
  input  logic [31:0] instr_i,
  output logic [31:0] lane_o
);
  localparam logic [1:0] IDX_L = IDX[1:0];

  always_comb begin
    if (IDX_L < slot_i)       lane_o = asm_i;
    else if (IDX_L == slot_i) lane_o = instr_i;
    else                      lane_o = NOP_INSTR;
  end
endmodule

module instr_packer #(
  parameter logic [3:0]  OPC_END_ISEQ = 4'b1111,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             app_en,
  input  logic [31:0]      app_instr,
  output logic             app_ack,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [127:0]     fifo_din,
  input  logic             dispatcher_busy,
  output logic             process_tr,
  output logic             idle,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_FLUSH, S_DONE, S_WAIT
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] asm_q, asm_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] merged;
  logic [1:0]                      slot_q, slot_d;
  logic [127:0]                    pend_q, pend_d;
  logic                            pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            seen_q, seen_d;   // busy observed in WAIT

  logic accept, is_end;

  assign accept     = app_en & app_ack;
  assign is_end     = (app_instr[31:28] == OPC_END_ISEQ);
  assign fifo_din   = pend_q;
  assign fifo_wr_en = pend_vld_q & ~fifo_full;
  assign instr_cnt  = cnt_q;

  // Word as it would look with app_instr placed in the current slot.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    instr_packer_slot #(.IDX(g), .NOP_INSTR(NOP_INSTR)) u_slot (
      .slot_i  (slot_q),
      .asm_i   (asm_q[g]),
      .instr_i (app_instr),
      .lane_o  (merged[g])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!dispatcher_busy) state_d = S_COLLECT;
      S_COLLECT: if (accept && is_end) state_d = S_FLUSH;
      // Leave as soon as the last word is gone or leaving this cycle.
      S_FLUSH:   if (!pend_vld_q || fifo_wr_en) state_d = S_DONE;
      S_DONE:    state_d = S_WAIT;
      S_WAIT:    if (seen_q && !dispatcher_busy) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    app_ack    = 1'b0;
    idle       = 1'b0;
    process_tr = 1'b0;
    case (state_q)
      S_IDLE:    idle       = 1'b1;
      // A pending word that cannot drain blocks new input, so a slot-3
      // accept can never overwrite an unwritten word.
      S_COLLECT: app_ack    = ~pend_vld_q | ~fifo_full;
      S_DONE:    process_tr = 1'b1;
      default:   ;
    endcase
  end

  // Datapath next state
  always_comb begin
    asm_d      = asm_q;
    slot_d     = slot_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q & ~fifo_wr_en;
    cnt_d      = cnt_q;
    seen_d     = seen_q;

    if (accept) begin
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
      if (is_end || slot_q == 2'd3) begin
        // Reload may coincide with the old word draining: full throughput.
        pend_d     = merged;
        pend_vld_d = 1'b1;
        asm_d      = '0;
        slot_d     = 2'd0;
      end else begin
        asm_d  = merged;
        slot_d = slot_q + 2'd1;
      end
    end

    if (state_q == S_DONE) seen_d = 1'b0;
    if (state_q == S_WAIT) seen_d = seen_q | dispatcher_busy;
    if (state_q == S_WAIT && state_d == S_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      slot_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      seen_q     <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      slot_q     <= slot_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
    end
  end
endmodule

// File: tb/tb_instr_packer.sv
module tb_instr_packer;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] END = 32'hF000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         app_en = 1'b0;
  logic [31:0]  app_instr = '0;
  logic         app_ack;
  logic         fifo_full = 1'b0;
  logic         fifo_wr_en;
  logic [127:0] fifo_din;
  logic         dispatcher_busy = 1'b0;
  logic         process_tr;
  logic         idle;
  logic [15:0]  instr_cnt;

  instr_packer dut (
    .clk(clk), .rst_n(rst_n), .app_en(app_en), .app_instr(app_instr),
    .app_ack(app_ack), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .dispatcher_busy(dispatcher_busy),
    .process_tr(process_tr), .idle(idle), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0, nwr = 0, nptr = 0, last_wr = -100;

  // Reference model: accepted instructions gathered into words of four.
  logic [31:0]  cur[$];
  logic [127:0] expq[$];
  logic [31:0]  seq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input logic [31:0] ins);
    logic [127:0] w;
    cur.push_back(ins);
    if (ins[31:28] == 4'hF || cur.size() == 4) begin
      w = '0;
      for (int i = 0; i < 4; i++) w[i*32 +: 32] = (i < cur.size()) ? cur[i] : NOP;
      expq.push_back(w);
      cur.delete();
    end
  endtask

  task automatic step(input bit en, input logic [31:0] ins, input bit full, input bit busy);
    @(negedge clk);
    app_en = en; app_instr = ins; fifo_full = full; dispatcher_busy = busy;
    #2;
    cyc++;
    if (full) chk("no_wr_while_full", fifo_wr_en, 0);
    if (full && expq.size() > 0) chk("ack_low_while_blocked", app_ack, 0);
    if (fifo_wr_en) begin
      nwr++;
      last_wr = cyc;
      if (expq.size() == 0) chk("spurious_write", 1, 0);
      else chk("fifo_word", fifo_din, expq.pop_front());
    end
    if (process_tr) nptr++;
    if (en && app_ack) model_accept(ins);
    if (expq.size() > 1) chk("word_overwritten", expq.size(), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; app_en = 1'b0; fifo_full = 1'b0; dispatcher_busy = 1'b0;
    cur.delete(); expq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    r = $urandom;
    if (r[31:28] == 4'hF) r[31:28] = 4'h7;
    return r;
  endfunction

  // Send seq[] (last entry is END), drain, then run the dispatcher handshake.
  task automatic run_seq(input int en_pct, input bit full_win, input int exp_writes);
    int sent = 0, fcnt = 0, guard = 0, wr0, ptr0, expcnt;
    bit en, full, seen;
    wr0 = nwr; ptr0 = nptr;
    expcnt = (seq.size() > 65535) ? 65535 : seq.size();
    while (sent < seq.size() && guard < 4 * seq.size() + 100) begin
      en   = ($urandom_range(99) < en_pct);
      full = full_win && sent >= 4 && fcnt < 8;
      if (full) fcnt++;
      step(en, en ? seq[sent] : $urandom, full, 1'b0);
      if (sent > 0 && !full) chk("ack_in_collect", app_ack, 1);
      if (en && app_ack) sent++;
      guard++;
    end
    if (sent < seq.size()) chk("send_timeout", sent, seq.size());
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, rnd_instr(), 1'b0, 1'b0);
      if (i == 0) chk("cnt_after_seq", instr_cnt, expcnt);
      if (app_ack) chk("ack_after_end", app_ack, 0);
      if (process_tr) begin
        seen = 1;
        chk("ptr_one_after_last_write", cyc, last_wr + 1);
      end
    end
    if (!seen) chk("ptr_timeout", 0, 1);
    repeat (2) step(1'b0, '0, 1'b0, 1'b0);
    chk("ptr_pulse_count", nptr - ptr0, 1);
    chk("write_count", nwr - wr0, exp_writes);
    chk("model_drained", expq.size() + cur.size(), 0);
    repeat (5) step(1'b0, '0, 1'b0, 1'b1);
    chk("idle_while_busy", idle, 0);
    for (int i = 0; i < 10 && !idle; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("idle_after_dispatch", idle, 1);
    chk("cnt_cleared", instr_cnt, 0);
  endtask

  typedef struct {
    bit en; logic [31:0] ins; bit busy;
    bit ack; bit wr; logic [127:0] din; bit ptr; bit idl; logic [15:0] cnt;
  } vec_t;
  vec_t tv[13];

  function automatic vec_t mkv(bit en, logic [31:0] ins, bit busy, bit ack, bit wr,
                               logic [127:0] din, bit ptr, bit idl, logic [15:0] cnt);
    vec_t v;
    v.en = en; v.ins = ins; v.busy = busy; v.ack = ack; v.wr = wr;
    v.din = din; v.ptr = ptr; v.idl = idl; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w2;
    int acc;
    w2 = {NOP, END, 32'h1000_0002, 32'h1000_0001};
    tv[0]  = mkv(1, 32'h1000_0001, 0, 0, 0, '0, 0, 1, 0);
    tv[1]  = mkv(1, 32'h1000_0001, 0, 1, 0, '0, 0, 0, 0);
    tv[2]  = mkv(1, 32'h1000_0002, 0, 1, 0, '0, 0, 0, 1);
    tv[3]  = mkv(1, END,           0, 1, 0, '0, 0, 0, 2);
    tv[4]  = mkv(0, '0,            0, 0, 1, w2, 0, 0, 3);
    tv[5]  = mkv(0, '0,            0, 0, 0, '0, 1, 0, 3);
    for (int i = 6; i <= 10; i++) tv[i] = mkv(0, '0, 1, 0, 0, '0, 0, 0, 3);
    tv[11] = mkv(0, '0,            0, 0, 0, '0, 0, 0, 3);
    tv[12] = mkv(0, '0,            0, 0, 0, '0, 0, 1, 0);

    // Reset values while rst_n is held low from time zero.
    #1;
    chk("rst_ack", app_ack, 0);
    chk("rst_wr", fifo_wr_en, 0);
    chk("rst_ptr", process_tr, 0);
    chk("rst_idle", idle, 1);
    chk("rst_cnt", instr_cnt, 0);

    // Two instructions then END, cycle by cycle, with dispatcher handshake.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tv[i].en, tv[i].ins, 1'b0, tv[i].busy);
      chk($sformatf("tv%0d_ack", i), app_ack, tv[i].ack);
      chk($sformatf("tv%0d_wr", i), fifo_wr_en, tv[i].wr);
      if (tv[i].wr) chk($sformatf("tv%0d_din", i), fifo_din, tv[i].din);
      chk($sformatf("tv%0d_ptr", i), process_tr, tv[i].ptr);
      chk($sformatf("tv%0d_idle", i), idle, tv[i].idl);
      chk($sformatf("tv%0d_cnt", i), instr_cnt, tv[i].cnt);
    end

    // 8 instructions + END at full rate: 3 writes.
    do_reset();
    seq.delete();
    for (int i = 1; i <= 8; i++) seq.push_back(32'h1000_0000 + i);
    seq.push_back(END);
    run_seq(100, 1'b0, 3);

    // FIFO full for 8 cycles from the 5th instruction, 20 instructions.
    do_reset();
    seq.delete();
    for (int i = 0; i < 19; i++) seq.push_back(rnd_instr());
    seq.push_back(END);
    run_seq(100, 1'b1, 5);

    // Random app_en, 40 instructions + END: 11 writes.
    do_reset();
    seq.delete();
    for (int i = 0; i < 40; i++) seq.push_back(rnd_instr());
    seq.push_back(END);
    run_seq(50, 1'b0, 11);

    // END in slot 3: word written unpadded.
    do_reset();
    seq.delete();
    for (int i = 0; i < 3; i++) seq.push_back(rnd_instr());
    seq.push_back(32'hF123_4567);
    run_seq(100, 1'b0, 1);

    // Asynchronous reset with slot == 2, then a fresh sequence.
    do_reset();
    acc = 0;
    for (int i = 0; i < 20 && acc < 6; i++) begin
      step(1'b1, rnd_instr(), 1'b0, 1'b0);
      if (app_ack) acc++;
    end
    chk("pre_reset_accepts", acc, 6);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", app_ack, 0);
    chk("async_rst_wr", fifo_wr_en, 0);
    chk("async_rst_ptr", process_tr, 0);
    chk("async_rst_idle", idle, 1);
    chk("async_rst_cnt", instr_cnt, 0);
    cur.delete(); expq.delete();
    app_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    seq.delete();
    for (int i = 0; i < 3; i++) seq.push_back(rnd_instr());
    seq.push_back(END);
    run_seq(100, 1'b0, 1);

    // Counter saturation: 65540 instructions + END.
    do_reset();
    seq.delete();
    for (int i = 0; i < 65540; i++) seq.push_back(32'h2000_0000 + i);
    seq.push_back(END);
    run_seq(100, 1'b0, 16386);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
